alu_issue_arbiter: RTL

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - ALU issue arbiter with one-entry result register feeding the CDB.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
module alu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][3:0]         req_op,
  input  logic [NUM_REQ-1:0][15:0]        req_a,
  input  logic [NUM_REQ-1:0][15:0]        req_b,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            out_valid,
  output logic [15:0]                     out_data,
  output logic [TAG_W-1:0]                out_tag,
  input  logic                            cdb_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // lc3b_aluop encoding
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_PASS = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;

  logic             accept;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic [3:0]       op_sel;
  logic [15:0]      a_sel;
  logic [15:0]      b_sel;
  logic [3:0]       shamt;
  logic [15:0]      alu_result;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
`endif

  always_comb begin
    accept = !rst && !flush && (!out_valid || cdb_ready);
    found  = 1'b0;
    sel    = '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Search starts at the pointer and wraps around the requester ring.
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
`endif
    gnt = '0;
    if (accept && found) gnt[sel] = 1'b1;
  end

  always_comb begin
    op_sel = req_op[sel];
    a_sel  = req_a[sel];
    b_sel  = req_b[sel];
    shamt  = b_sel[3:0];
    case (op_sel)
      ALU_ADD:  alu_result = a_sel + b_sel;
      ALU_AND:  alu_result = a_sel & b_sel;
      ALU_NOT:  alu_result = ~a_sel;
      ALU_PASS: alu_result = a_sel;
      ALU_SLL:  alu_result = a_sel << shamt;
      ALU_SRL:  alu_result = a_sel >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(a_sel) >>> shamt);
      default:  alu_result = 16'h0000;
    endcase
  end

  // Flush beats both a new load and a CDB drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (|gnt) begin
      out_valid <= 1'b1;
      out_data  <= alu_result;
      out_tag   <= req_tag[sel];
    end else if (cdb_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

endmodule
